divide_fp_iter: RTL and testbench
=================================

// Module: divide_fp_iter
// PURPOSE
//  Parametrised iterative IEEE-754 divider; next generation of divide_f32.
//  Computes quo = num / den at any EXP_W/MAN_W (f16, f32, ...), producing one
//  quotient bit per cycle with a fixed latency and round-to-nearest-even.
//  Adds valid/ready handshakes, full special-case handling and exception flags.
//  Sits after int2float32-style converters in the PE arithmetic path.
// PARAMETERS
//  EXP_W  8   exponent width; BIAS = 2^(EXP_W-1)-1
//  MAN_W  23  stored mantissa width; W = 1+EXP_W+MAN_W; Q_BITS = MAN_W+3
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  asynchronous active-high reset
//  in_valid   in   1  num/den valid
//  in_ready   out  1  block can accept an operand pair
//  num        in   W  dividend
//  den        in   W  divisor
//  out_valid  out  1  quo/flags valid; held until out_ready
//  out_ready  in   1  consumer accepts result
//  quo        out  W  quotient
//  flags      out  4  {invalid, div_by_zero, overflow, underflow}
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1, out_valid=0, quo=0, flags=0; any op in flight is dropped.
//  States: IDLE -> DIV (Q_BITS cycles) -> ROUND (1) -> DONE; IDLE -> DONE for specials.
//  IDLE: in_ready=1; on in_valid capture operands, sign = num[W-1]^den[W-1].
//  DIV: restoring division of {1,man_n} by {1,man_d}, one bit/cycle, MSB first;
//   bit count in a counter; Q_BITS bits = 1 integer + MAN_W + guard + round.
//   Sticky = final remainder != 0.
//  ROUND: if q MSB=0, shift left 1 and decrement exp; exp = e_n - e_d + BIAS.
//   RNE on guard/round/sticky; a mantissa carry-out increments exp.
//   exp >= 2^EXP_W-1 -> signed inf, overflow=1; exp <= 0 -> signed zero, underflow=1.
//  DONE: out_valid=1; quo/flags stable while out_ready=0; on out_ready -> IDLE.
//   No new input is accepted in the handshake cycle.
//  Latency (normal): out_valid high after the (Q_BITS+2)-th rising edge past accept.
//   For f32 this is 28 edges. Specials: after the 1st edge.
//  Subnormal inputs (exp=0) are treated as zero; results never subnormal (flush to zero).
//  Specials (priority order):
//   NaN in          -> qNaN {0,all-ones exp,1,0..}; invalid=0 (quiet propagation)
//   0/0 or inf/inf  -> qNaN, invalid=1
//   x/0, x finite   -> signed inf, div_by_zero=1
//   inf/x           -> signed inf
//   0/x or x/inf    -> signed zero
//  Flags are cleared on every new accept; they describe only the current quo.
//  in_valid while busy is ignored (in_ready=0); the source must hold its operands.
// TESTING (EXP_W=8, MAN_W=23)
//  0x40800000/0x40000000 (4/2) -> quo=0x40000000, flags=0, out_valid on edge 28
//  0x40800000/0x40400000 (4/3) -> 0x3FAAAAAB (RNE rounds up), flags=0
//  0x43410000/0x43C10000 (193/386) -> 0x3F000000; 0xCF000000/0x4F000000 -> 0xBF800000
//  Specials: 0x3F800000/0 -> 0x7F800000, flags=0100; 0/0 -> 0x7FC00000, flags=1000;
//   both complete in 1 edge
//  0x7F7FFFFF/0x3F000000 -> 0x7F800000, flags=0010;
//   0x00800000/0x40000000 -> 0x00000000, flags=0001
//  Hold out_ready=0 for 10 cycles: quo stable, in_ready=0. Assert rst mid-DIV:
//   out_valid=0 immediately, in_ready=1; the next op completes correctly.

Source files
------------

// File: rtl/divide_fp_iter.sv
// Iterative IEEE-754 divider: one quotient bit per cycle (restoring),
// round-to-nearest-even, flush-to-zero, valid/ready handshakes, exception flags.
module divide_fp_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   num,
  input  logic [EXP_W+MAN_W:0]   den,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   quo,
  output logic [3:0]             flags
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int Q_BITS = MAN_W + 3;
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
  localparam int CNT_W  = $clog2(Q_BITS);
  localparam int XW     = EXP_W + 2;

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(Q_BITS - 1);
  localparam logic [EXP_W-1:0]    EXP_ONES = '1;
  localparam logic [W-1:0]        QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_ROUND, S_DONE} state_t;

  state_t                 state_q;
  logic                   in_ready_q, out_valid_q, sign_q;
  logic [W-1:0]           quo_q;
  logic [3:0]             flags_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [MAN_W+1:0]       rem_q, rem_d;
  logic [MAN_W:0]         div_q;
  logic [Q_BITS-1:0]      q_q, q_d;
  logic signed [XW-1:0]   exp_q;

  // Operand decode (exp==0 means zero: subnormals are flushed on input)
  logic [EXP_W-1:0] e_n, e_d;
  logic [MAN_W-1:0] m_n, m_d;
  logic             n_zero, n_inf, n_nan, d_zero, d_inf, d_nan, sign_in;
  logic [XW-1:0]    exp_in;

  assign e_n     = num[W-2:MAN_W];
  assign e_d     = den[W-2:MAN_W];
  assign m_n     = num[MAN_W-1:0];
  assign m_d     = den[MAN_W-1:0];
  assign n_zero  = (e_n == '0);
  assign d_zero  = (e_d == '0);
  assign n_inf   = (e_n == EXP_ONES) && (m_n == '0);
  assign d_inf   = (e_d == EXP_ONES) && (m_d == '0);
  assign n_nan   = (e_n == EXP_ONES) && (m_n != '0);
  assign d_nan   = (e_d == EXP_ONES) && (m_d != '0);
  assign sign_in = num[W-1] ^ den[W-1];
  assign exp_in  = XW'(e_n) - XW'(e_d) + XW'(BIAS);

  // Special-case result selection in priority order
  logic         special;
  logic [W-1:0] spec_quo;
  logic [3:0]   spec_flags;
  always_comb begin
    special    = 1'b1;
    spec_quo   = QNAN;
    spec_flags = '0;
    if (n_nan || d_nan) begin
      spec_quo = QNAN;
    end else if ((n_zero && d_zero) || (n_inf && d_inf)) begin
      spec_flags = 4'b1000;
    end else if (d_zero && !n_inf) begin
      spec_quo   = {sign_in, EXP_ONES, {MAN_W{1'b0}}};
      spec_flags = 4'b0100;
    end else if (n_inf) begin
      spec_quo = {sign_in, EXP_ONES, {MAN_W{1'b0}}};
    end else if (n_zero || d_inf) begin
      spec_quo = {sign_in, {(W-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // One restoring-division step: subtract if possible, emit bit, shift remainder
  logic             rem_ge;
  logic [MAN_W+1:0] rem_sub;
  always_comb begin
    rem_ge  = (rem_q >= {1'b0, div_q});
    rem_sub = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;
    rem_d   = rem_sub << 1;
    q_d     = {q_q[Q_BITS-2:0], rem_ge};
  end

  // Normalise, round to nearest even, and classify exponent range
  logic [Q_BITS-2:0]    norm;
  logic signed [XW-1:0] exp_r;
  logic                 sticky, round_up, frac_co, ovf, unf;
  logic [MAN_W-1:0]     frac_r;
  always_comb begin
    // The leading 1 is implicit after normalisation, so only the bits below it are kept
    norm     = q_q[Q_BITS-1] ? q_q[Q_BITS-2:0] : {q_q[Q_BITS-3:0], 1'b0};
    exp_r    = q_q[Q_BITS-1] ? exp_q : (exp_q - XW'(1));
    sticky   = (rem_q != '0);
    round_up = norm[1] & (norm[0] | sticky | norm[2]);
    {frac_co, frac_r} = {1'b0, norm[Q_BITS-2:2]} + (MAN_W+1)'(round_up);
    if (frac_co) exp_r = exp_r + XW'(1);
    ovf = (exp_r >= EXP_MAX);
    unf = exp_r[XW-1] | (exp_r == '0);
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      quo_q       <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      q_q         <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            flags_q    <= '0;
            sign_q     <= sign_in;
            rem_q      <= {1'b0, 1'b1, m_n};
            div_q      <= {1'b1, m_d};
            q_q        <= '0;
            cnt_q      <= '0;
            exp_q      <= exp_in;
            if (special) begin
              quo_q       <= spec_quo;
              flags_q     <= spec_flags;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_DIV;
            end
          end
        end
        S_DIV: begin
          rem_q <= rem_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) state_q <= S_ROUND;
        end
        S_ROUND: begin
          if (ovf)      quo_q <= {sign_q, EXP_ONES, {MAN_W{1'b0}}};
          else if (unf) quo_q <= {sign_q, {(W-1){1'b0}}};
          else          quo_q <= {sign_q, exp_r[EXP_W-1:0], frac_r};
          flags_q     <= {2'b00, ovf, unf & ~ovf};
          out_valid_q <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quo       = quo_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_divide_fp_iter.sv
// Testbench for divide_fp_iter (f32): directed vectors, randomized operands
// against an arbitrary-precision integer reference, latency and handshake checks.
module tb_divide_fp_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] num = '0;
  logic [31:0] den = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quo;
  logic [3:0]  flags;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divide_fp_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .den       (den),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quo       (quo),
    .flags     (flags)
  );

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_special(input logic [31:0] a, input logic [31:0] b);
    return (a[30:23] == 8'hFF) || (a[30:23] == 8'h00) ||
           (b[30:23] == 8'hFF) || (b[30:23] == 8'h00);
  endfunction

  // Reference: {flags, quo} from exact integer quotient with RNE at 24 bits
  function automatic logic [35:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int     ea, eb, e, d;
    longint ma, mb, q, r, rb, half, mant;
    logic   s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, up;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan) return {4'b0000, 32'h7FC00000};
    if ((a_zero && b_zero) || (a_inf && b_inf)) return {4'b1000, 32'h7FC00000};
    if (b_zero && !a_inf) return {4'b0100, s, 31'h7F800000};
    if (a_inf) return {4'b0000, s, 31'h7F800000};
    if (a_zero || b_inf) return {4'b0000, s, 31'h0};
    ma = longint'(a[22:0]) | (64'sd1 << 23);
    mb = longint'(b[22:0]) | (64'sd1 << 23);
    q  = (ma << 26) / mb;
    r  = (ma << 26) % mb;
    e  = ea - eb + 127;
    if (q >= (64'sd1 << 26)) d = 3;
    else begin
      d = 2;
      e = e - 1;
    end
    mant = q >> d;
    rb   = q & ((64'sd1 << d) - 1);
    half = 64'sd1 << (d - 1);
    up   = (rb > half) || ((rb == half) && ((r != 0) || mant[0]));
    if (up) mant = mant + 1;
    if (mant == (64'sd1 << 24)) begin
      mant = 64'sd1 << 23;
      e    = e + 1;
    end
    if (e >= 255) return {4'b0010, s, 31'h7F800000};
    if (e <= 0)   return {4'b0001, s, 31'h0};
    return {4'b0000, s, 8'(e), mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 19))
      0:       v[30:0] = '0;
      1:       v[30:0] = {8'hFF, 23'h0};
      2:       begin v[30:23] = 8'hFF; v[0] = 1'b1; end
      3:       v[30:23] = 8'h00;
      4:       v[30:23] = 8'hFE;
      5:       v[30:23] = 8'h01;
      6:       begin v[30:23] = 8'($urandom_range(100, 154)); v[22:0] = '0; end
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                        input string tag, output logic [35:0] got);
    logic [35:0] exp_res;
    int          edges;
    int          exp_lat;
    exp_res = ref_div(a, b);
    exp_lat = is_special(a, b) ? 1 : 28;
    @(negedge clk);
    check({tag, ":in_ready"}, 36'(in_ready), 36'd1);
    in_valid = 1'b1;
    num = a;
    den = b;
    @(posedge clk);
    edges = 1;
    #1;
    in_valid = 1'b0;
    num = $urandom;
    den = $urandom;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      edges++;
      #1;
    end
    got = {flags, quo};
    check({tag, ":latency"}, 36'(edges), 36'(exp_lat));
    check({tag, ":result"}, got, exp_res);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      num = $urandom;
      den = $urandom;
      @(posedge clk);
      #1;
      check({tag, ":hold_res"}, {flags, quo}, exp_res);
      check({tag, ":hold_hs"}, 36'({out_valid, in_ready}), 36'b10);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ":release"}, 36'({out_valid, in_ready}), 36'b01);
  endtask

  logic [31:0] d_a   [8] = '{32'h40800000, 32'h40800000, 32'h43410000, 32'hCF000000,
                              32'h3F800000, 32'h00000000, 32'h7F7FFFFF, 32'h00800000};
  logic [31:0] d_b   [8] = '{32'h40000000, 32'h40400000, 32'h43C10000, 32'h4F000000,
                              32'h00000000, 32'h00000000, 32'h3F000000, 32'h40000000};
  logic [35:0] d_exp [8] = '{{4'b0000, 32'h40000000}, {4'b0000, 32'h3FAAAAAB},
                              {4'b0000, 32'h3F000000}, {4'b0000, 32'hBF800000},
                              {4'b0100, 32'h7F800000}, {4'b1000, 32'h7FC00000},
                              {4'b0010, 32'h7F800000}, {4'b0001, 32'h00000000}};

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [35:0] got;
    #12;
    check("reset_hs", 36'({in_ready, out_valid}), 36'b10);
    check("reset_out", {flags, quo}, 36'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(d_a[i], d_b[i], (i == 0) ? 10 : 0, $sformatf("dir%0d", i), got);
      check($sformatf("dir%0d:spec", i), got, d_exp[i]);
    end

    // Asynchronous reset while the divider is mid-iteration
    @(negedge clk);
    in_valid = 1'b1;
    num = 32'h40800000;
    den = 32'h40400000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_hs", 36'({out_valid, in_ready}), 36'b01);
    check("rst_mid_out", {flags, quo}, 36'h0);
    @(negedge clk);
    rst = 1'b0;
    run_op(32'h40800000, 32'h40400000, 0, "after_rst", got);
    check("after_rst:spec", got, {4'b0000, 32'h3FAAAAAB});

    for (int i = 0; i < 150; i++) begin
      run_op(rand_fp(), rand_fp(), $urandom_range(0, 2), $sformatf("rnd%0d", i), got);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
